// File: rtl/pixel_ctrl_pkg.sv
// Shared types and default sizing for the pixel array frame sequencer.
package pixel_ctrl_pkg;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_N_PIX      = 4;
    localparam int DEF_ERASE_CYC  = 5;
    localparam int DEF_EXPOSE_CYC = 255;
    localparam int DEF_CONV_CYC   = 255;

    // Phase counter width; wide enough for a 16-bit programmable exposure.
    localparam int PH_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        ERASE,
        EXPOSE,
        CONVERT,
        READ,
        STREAM
    } state_e;

endpackage

// File: rtl/ctrl_phase_counter.sv
// Loadable down-counter; tc_o is high while the count sits at zero.
module ctrl_phase_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] load_val_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/pixel_array_ctrl.sv
// Frame sequencer ERASE -> EXPOSE -> CONVERT -> READ -> STREAM for the pixel array.
// Optional PIXEL_ARRAY_CTRL_PROG_EXPOSE_EN: per-frame exposure length from expose_cyc_in.
module pixel_array_ctrl
    import pixel_ctrl_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int N_PIX      = DEF_N_PIX,
    parameter int ERASE_CYC  = DEF_ERASE_CYC,
    parameter int EXPOSE_CYC = DEF_EXPOSE_CYC,
    parameter int CONV_CYC   = DEF_CONV_CYC,
    localparam int IDX_W     = (N_PIX > 1) ? $clog2(N_PIX) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic                    pix_reset,
    output logic                    pix_erase,
    output logic                    pix_expose,
    output logic                    pix_read,
    output logic                    ramp_en,
    output logic [DATA_W-1:0]       cnt_value,
    output logic                    cnt_oe,
    input  logic [N_PIX*DATA_W-1:0] pix_data_in,
`ifdef PIXEL_ARRAY_CTRL_PROG_EXPOSE_EN
    input  logic [15:0]             expose_cyc_in,
    output logic                    expose_cyc_err,
`endif
    output logic [DATA_W-1:0]       out_data,
    output logic [IDX_W-1:0]        out_idx,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam logic [DATA_W-1:0] CONV_LAST = DATA_W'(CONV_CYC);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_PIX - 1);

    state_e state_q, state_d;

    logic                           ph_load, ph_en, ph_tc;
    logic [PH_W-1:0]                ph_val;
    logic [PH_W-1:0]                expose_len;
    logic [DATA_W-1:0]              cnt_q, cnt_d;
    logic [N_PIX-1:0][DATA_W-1:0]   cap_q, cap_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic                           beat;

    logic busy_q, rst_pix_q, erase_q, expose_q, read_q, ramp_q, oe_q, out_valid_q;
    logic [DATA_W-1:0] out_data_q;

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat    = (state_q == STREAM) && out_valid_q && out_ready;
        case (state_q)
            IDLE:    if (start)              state_d = ERASE;
            ERASE:   if (ph_tc)              state_d = EXPOSE;
            EXPOSE:  if (ph_tc)              state_d = CONVERT;
            CONVERT: if (cnt_q == CONV_LAST) state_d = READ;
            READ:    if (ph_tc)              state_d = STREAM;
            STREAM:  if (beat && (idx_q == IDX_LAST)) state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

`ifdef PIXEL_ARRAY_CTRL_PROG_EXPOSE_EN
    logic [PH_W-1:0] exp_len_q;
    logic            exp_err_q;
    logic            frame_go;

    assign frame_go = (state_q == IDLE) && (state_d == ERASE);

    // A requested length of zero still gets a single exposure cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_len_q <= '0;
            exp_err_q <= 1'b0;
        end else begin
            exp_err_q <= frame_go && (expose_cyc_in == '0);
            if (frame_go) begin
                exp_len_q <= (expose_cyc_in == '0) ? PH_W'(1) : PH_W'(expose_cyc_in);
            end
        end
    end

    assign expose_len     = exp_len_q;
    assign expose_cyc_err = exp_err_q;
`else
    assign expose_len = PH_W'(EXPOSE_CYC);
`endif

    // One down-counter times ERASE, EXPOSE and READ; loaded with length-1 on entry.
    always_comb begin
        ph_load = (state_d != state_q) && (state_d inside {ERASE, EXPOSE, READ});
        ph_en   = state_q inside {ERASE, EXPOSE, READ};
        case (state_d)
            ERASE:   ph_val = PH_W'(ERASE_CYC - 1);
            EXPOSE:  ph_val = expose_len - PH_W'(1);
            READ:    ph_val = PH_W'(1);
            default: ph_val = '0;
        endcase
    end

    ctrl_phase_counter #(
        .W (PH_W)
    ) u_phase_cnt (
        .clk        (clk),
        .rst_n      (reset),
        .load_i     (ph_load),
        .en_i       (ph_en),
        .load_val_i (ph_val),
        .tc_o       (ph_tc)
    );

    always_comb begin
        cnt_d = ((state_q == CONVERT) && (state_d == CONVERT)) ? cnt_q + DATA_W'(1) : '0;
        cap_d = ((state_q == READ) && ph_tc) ? pix_data_in : cap_q;
        if (state_d == STREAM) begin
            idx_d = beat ? idx_q + IDX_W'(1) : idx_q;
        end else begin
            idx_d = '0;
        end
    end

    // Outputs are registered from next-state so they line up with state_q.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            cap_q       <= '0;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            rst_pix_q   <= 1'b0;
            erase_q     <= 1'b0;
            expose_q    <= 1'b0;
            read_q      <= 1'b0;
            ramp_q      <= 1'b0;
            oe_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            cnt_q       <= cnt_d;
            cap_q       <= cap_d;
            idx_q       <= idx_d;
            busy_q      <= (state_d != IDLE);
            rst_pix_q   <= (state_d == ERASE);
            erase_q     <= (state_d == ERASE);
            expose_q    <= (state_d == EXPOSE);
            read_q      <= (state_d == READ);
            ramp_q      <= (state_d == CONVERT);
            oe_q        <= (state_d == CONVERT);
            out_valid_q <= (state_d == STREAM);
            out_data_q  <= (state_d == STREAM) ? cap_d[idx_d] : '0;
        end
    end

    assign busy       = busy_q;
    assign pix_reset  = rst_pix_q;
    assign pix_erase  = erase_q;
    assign pix_expose = expose_q;
    assign pix_read   = read_q;
    assign ramp_en    = ramp_q;
    assign cnt_oe     = oe_q;
    assign cnt_value  = cnt_q;
    assign out_valid  = out_valid_q;
    assign out_idx    = idx_q;
    assign out_data   = out_data_q;

    // The count drivers and the pixel read drivers share the buses.
    a_no_bus_contention: assert property (@(posedge clk) disable iff (!reset) !(oe_q && read_q));

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// Bench for pixel_array_ctrl: timeline model computed from the phase lengths plus a beat queue.
module tb_pixel_array_ctrl;

    localparam int DW = 8;
    localparam int NP = 4;
    localparam int IW = 2;
    localparam int EC = 5;
    localparam int XC = 255;
    localparam int CC = 255;
    localparam int LAT = EC + XC + CC + 1 + 2 + 1;

    logic            clk = 1'b0;
    logic            reset, start, out_ready;
    logic [NP*DW-1:0] pix_data_in;
    logic            busy, pix_reset, pix_erase, pix_expose, pix_read, ramp_en, cnt_oe, out_valid;
    logic [DW-1:0]   cnt_value, out_data;
    logic [IW-1:0]   out_idx;
`ifdef PIXEL_ARRAY_CTRL_PROG_EXPOSE_EN
    logic [15:0]     expose_cyc_in;
    logic            expose_cyc_err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pixel_array_ctrl #(
        .DATA_W (DW), .N_PIX (NP), .ERASE_CYC (EC), .EXPOSE_CYC (XC), .CONV_CYC (CC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .busy           (busy),
        .pix_reset      (pix_reset),
        .pix_erase      (pix_erase),
        .pix_expose     (pix_expose),
        .pix_read       (pix_read),
        .ramp_en        (ramp_en),
        .cnt_value      (cnt_value),
        .cnt_oe         (cnt_oe),
        .pix_data_in    (pix_data_in),
`ifdef PIXEL_ARRAY_CTRL_PROG_EXPOSE_EN
        .expose_cyc_in  (expose_cyc_in),
        .expose_cyc_err (expose_cyc_err),
`endif
        .out_data       (out_data),
        .out_idx        (out_idx),
        .out_valid      (out_valid),
        .out_ready      (out_ready)
    );

    // Runs one frame from the current negedge (DUT idle). Cycle 0 is the cycle start is sampled in.
    // ready_mode: 0 always ready, 1 stall 10 cycles on beat 2, 2 random.
    task automatic run_frame(input logic [NP*DW-1:0] pix, input int ready_mode, input bit keep_start,
                             input bit toggle_start, input int exp_req, output int first_vld);
        int k, beats, stall, xlen, x0, c0, r0, s0;
        bit done, rdy;
        logic [14:0] exp_ctrl, got_ctrl;
        logic [10:0] exp_str, got_str;
        xlen = XC;
`ifdef PIXEL_ARRAY_CTRL_PROG_EXPOSE_EN
        xlen = (exp_req == 0) ? 1 : exp_req;
        expose_cyc_in = 16'(exp_req);
`endif
        x0 = 1 + EC;
        c0 = x0 + xlen;
        r0 = c0 + CC + 1;
        s0 = r0 + 2;
        pix_data_in = pix;
        start = 1'b1;
        out_ready = 1'b1;
        k = 0; beats = 0; stall = 0; done = 1'b0; first_vld = -1;
        while (!done && k < 3000) begin
            @(negedge clk);
            k++;
            if (beats == NP) begin
                exp_ctrl = '0;
                exp_str  = '0;
                done = 1'b1;
            end else begin
                exp_ctrl = {1'b1, k < x0, k < x0, (k >= x0) && (k < c0), (k >= r0) && (k < s0),
                            (k >= c0) && (k < r0), (k >= c0) && (k < r0),
                            ((k >= c0) && (k < r0)) ? DW'(k - c0) : DW'(0)};
                exp_str  = (k >= s0) ? {1'b1, IW'(beats), pix[beats*DW +: DW]} : 11'd0;
            end
            got_ctrl = {busy, pix_reset, pix_erase, pix_expose, pix_read, ramp_en, cnt_oe, cnt_value};
            got_str  = {out_valid, out_idx, out_data};
            if (out_valid && first_vld < 0) first_vld = k;
            checks++;
            if (got_ctrl !== exp_ctrl) begin
                errors++;
                $display("FAIL ctrl cycle %0d: got %b expected %b", k, got_ctrl, exp_ctrl);
            end
            checks++;
            if (got_str !== exp_str) begin
                errors++;
                $display("FAIL stream cycle %0d: got vld/idx/data %h expected %h", k, got_str, exp_str);
            end
            checks++;
            if ((cnt_oe && pix_read) !== 1'b0) begin
                errors++;
                $display("FAIL contention cycle %0d: cnt_oe and pix_read both high", k);
            end
`ifdef PIXEL_ARRAY_CTRL_PROG_EXPOSE_EN
            checks++;
            if (expose_cyc_err !== ((k == 1) && (exp_req == 0))) begin
                errors++;
                $display("FAIL expose_err cycle %0d: got %b expected %b", k, expose_cyc_err,
                         (k == 1) && (exp_req == 0));
            end
`endif
            if (keep_start) start = 1'b1;
            else if (toggle_start && k >= x0 && k < c0) start = 1'($urandom_range(0, 1));
            else start = 1'b0;
            if (!done && k >= s0 && beats < NP) begin
                case (ready_mode)
                    0: rdy = 1'b1;
                    1: begin
                        rdy = !((beats == 2) && (stall < 10));
                        if (!rdy) stall++;
                    end
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                out_ready = rdy;
                if (rdy) beats++;
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL frame_timeout: frame not finished after %0d cycles, beats %0d", k, beats);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; out_ready = 1'b0; pix_data_in = '0;
`ifdef PIXEL_ARRAY_CTRL_PROG_EXPOSE_EN
        expose_cyc_in = 16'd0;
`endif
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, pix_reset, pix_erase, pix_expose, pix_read, ramp_en, cnt_oe, cnt_value,
             out_valid, out_idx, out_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: outputs not all zero during reset");
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, out_valid} !== 2'b00) begin
            errors++;
            $display("FAIL reset_release: busy/out_valid %b expected 00", {busy, out_valid});
        end
    endtask

    task automatic test_basic_frame();
        int fv;
        run_frame(NP*DW'($urandom), 0, 1'b0, 1'b0, XC, fv);
        checks++;
        if (fv !== LAT) begin
            errors++;
            $display("FAIL latency: first out_valid at cycle %0d expected %0d", fv, LAT);
        end
    endtask

    task automatic test_directed_data();
        int fv;
        logic [NP*DW-1:0] pix;
        pix = {8'hE6, 8'hB3, 8'h80, 8'h33};
        run_frame(pix, 0, 1'b0, 1'b0, XC, fv);
    endtask

    task automatic test_backpressure();
        int fv;
        run_frame(NP*DW'($urandom), 1, 1'b0, 1'b0, XC, fv);
    endtask

    task automatic test_random_ready();
        int fv;
        repeat (2) run_frame(NP*DW'($urandom), 2, 1'b0, 1'b0, XC, fv);
    endtask

    task automatic test_start_ignored();
        int fv;
        run_frame(NP*DW'($urandom), 0, 1'b0, 1'b1, XC, fv);
        checks++;
        if (fv !== LAT) begin
            errors++;
            $display("FAIL start_ignored_latency: first out_valid at %0d expected %0d", fv, LAT);
        end
    endtask

    task automatic test_back_to_back();
        int fv;
        for (int f = 0; f < 3; f++) run_frame(NP*DW'($urandom), 2, 1'b1, 1'b0, XC, fv);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stop: busy %b expected 0 after start dropped", busy);
        end
    endtask

    task automatic test_reset_mid();
        int k;
        pix_data_in = NP*DW'($urandom);
`ifdef PIXEL_ARRAY_CTRL_PROG_EXPOSE_EN
        expose_cyc_in = 16'(XC);
`endif
        start = 1'b1; out_ready = 1'b1; k = 0;
        do begin
            @(negedge clk);
            k++;
            start = 1'b0;
        end while (!(cnt_oe && cnt_value == 8'd100) && k < 2000);
        checks++;
        if (k !== 1 + EC + XC + 100) begin
            errors++;
            $display("FAIL count_100_cycle: reached at %0d expected %0d", k, 1 + EC + XC + 100);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({busy, pix_reset, pix_erase, pix_expose, pix_read, ramp_en, cnt_oe, cnt_value,
             out_valid, out_idx, out_data} !== '0) begin
            errors++;
            $display("FAIL async_reset: outputs not zero right after reset asserted");
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({busy, out_valid, cnt_oe, pix_read} !== 4'b0000) begin
                errors++;
                $display("FAIL post_reset_idle cycle %0d: busy/vld/oe/read %b expected 0000", i,
                         {busy, out_valid, cnt_oe, pix_read});
            end
        end
    endtask

`ifdef PIXEL_ARRAY_CTRL_PROG_EXPOSE_EN
    task automatic test_prog_expose();
        int fv;
        run_frame(NP*DW'($urandom), 0, 1'b0, 1'b0, 10, fv);
        checks++;
        if (fv !== EC + 10 + CC + 4) begin
            errors++;
            $display("FAIL prog10_latency: got %0d expected %0d", fv, EC + 10 + CC + 4);
        end
        run_frame(NP*DW'($urandom), 0, 1'b0, 1'b0, 0, fv);
        checks++;
        if (fv !== EC + 1 + CC + 4) begin
            errors++;
            $display("FAIL prog0_latency: got %0d expected %0d", fv, EC + 1 + CC + 4);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_frame();
        test_directed_data();
        test_backpressure();
        test_random_ready();
        test_reset_mid();
        test_start_ignored();
        test_back_to_back();
`ifdef PIXEL_ARRAY_CTRL_PROG_EXPOSE_EN
        test_prog_expose();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_array_ctrl.md
Name: pixel_array_ctrl

Overview:
- Frame sequencer for the 4-pixel array: ERASE → EXPOSE → CONVERT → READ → STREAM.
- Drives the shared pixel controls (reset, erase, expose, read) and the ramp enable.
- During CONVERT, drives a Gray-free binary conversion count onto all four pixel data buses; pixels latch it when their comparator trips.
- Captures all four pixel values in one read cycle, then streams them out over a valid/ready interface.

Parameters:
- DATA_W, 8, pixel data and conversion counter width.
- N_PIX, 4, number of pixels/buses.
- ERASE_CYC, 5, cycles pix_erase and pix_reset stay high.
- EXPOSE_CYC, 255, cycles pix_expose stays high (≥1).
- CONV_CYC, 255, final counter value; CONVERT lasts CONV_CYC+1 cycles (≤2^DATA_W−1).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-low reset.
- start  in  1  request one frame; sampled in IDLE only.
- busy  out  1  high in every state except IDLE.
- pix_reset  out  1  pixel reset.
- pix_erase  out  1  pixel erase.
- pix_expose  out  1  pixel expose.
- pix_read  out  1  pixel read enable.
- ramp_en  out  1  ramp generator run/hold.
- cnt_value  out  DATA_W  conversion count, to bus tri-state drivers.
- cnt_oe  out  1  enables cnt_value onto all pixel buses.
- pix_data_in  in  N_PIX*DATA_W  bus values, pixel i at bits [i*DATA_W +: DATA_W].
- out_data  out  DATA_W  streamed pixel value.
- out_idx  out  $clog2(N_PIX)  pixel index of out_data.
- out_valid  out  1  out_data/out_idx valid.
- out_ready  in  1  consumer accepts the beat.

Behaviour:
Reset:
- FSM goes to IDLE; all outputs 0; capture registers 0; counters 0.
- Applies immediately mid-frame, with no partial beat afterwards.

States, one registered Moore FSM:
- IDLE: if start=1, go to ERASE next cycle.
- ERASE: pix_reset=pix_erase=1 for exactly ERASE_CYC cycles, then EXPOSE.
- EXPOSE: pix_expose=1 for exactly EXPOSE_CYC cycles, then CONVERT.
- CONVERT:
  - ramp_en=1 and cnt_oe=1.
  - cnt_value starts at 0 on the first CONVERT cycle and increments by 1 per cycle.
  - Leave after the cycle in which cnt_value=CONV_CYC; no wrap-around.
  - cnt_value returns to 0 and cnt_oe drops on the same edge.
- READ: exactly 2 cycles with pix_read=1 and cnt_oe=0.
  - Cycle 1 lets the bus settle.
  - At the end of cycle 2, all N_PIX slices of pix_data_in are registered.
  - Then STREAM.
- STREAM:
  - out_valid=1; out_idx starts at 0; out_data = captured[out_idx].
  - A beat completes on out_valid & out_ready. Then out_idx increments.
  - After beat N_PIX−1, go to IDLE with out_valid=0.
  - out_data/out_idx must hold stable while out_valid=1 and out_ready=0.

Timing and boundaries:
- Latency from start sampled to first out_valid = ERASE_CYC+EXPOSE_CYC+CONV_CYC+1+2+1 cycles.
- cnt_oe and pix_read are never high in the same cycle; tri-state contention is forbidden. Add an assertion for this.
- start outside IDLE is ignored; there is no queueing.
- start held high continuously produces back-to-back frames, with IDLE lasting 1 cycle between them.
- All control outputs come straight from registers; no combinational path from inputs to outputs except none. out_valid is registered.

Optional Feature:
- Macro: PIXEL_ARRAY_CTRL_PROG_EXPOSE_EN.
- When defined:
  - Extra ports expose_cyc_in [15:0] (input) and expose_cyc_err (output).
  - expose_cyc_in is sampled on the IDLE→ERASE transition and replaces EXPOSE_CYC for that frame.
  - A sampled value of 0 is treated as 1, and expose_cyc_err pulses high for one cycle.
- When undefined: no extra ports; exposure is fixed at EXPOSE_CYC.

Decomposition:
- Shared package pixel_ctrl_pkg:
  - state enum {IDLE, ERASE, EXPOSE, CONVERT, READ, STREAM}.
  - Default width/cycle localparams.
- Sub-module ctrl_phase_counter: loadable down-counter with a terminal-count flag. It is reused for the ERASE/EXPOSE/READ durations.
- The conversion up-counter stays in the top level because its value is an output.

Test Plan:
- Defaults, pulse start=1 for 1 cycle:
  - pix_erase high 5 cycles, then pix_expose high 255 cycles.
  - cnt_value runs 0..255 with cnt_oe high 256 cycles.
  - pix_read high 2 cycles; first out_valid exactly 519 cycles after start sampled.
- pix_data_in = {8'hE6, 8'hB3, 8'h80, 8'h33}, out_ready=1:
  - Four consecutive beats: (idx 0, 0x33), (1, 0x80), (2, 0xB3), (3, 0xE6).
  - busy drops the cycle after the last beat.
- out_ready=0 for 10 cycles on beat 2: out_valid stays 1, out_idx=2 and out_data stable; resumes on out_ready=1.
- reset low mid-CONVERT at cnt_value=100: all outputs 0 asynchronously; after release, FSM idle and no out_valid until a new start.
- start toggled during EXPOSE: ignored, frame timing unchanged. Checker confirms cnt_oe&pix_read never high in the same cycle across 3 back-to-back frames.
- With PIXEL_ARRAY_CTRL_PROG_EXPOSE_EN defined:
  - expose_cyc_in=10: pix_expose high 10 cycles.
  - expose_cyc_in=0: pix_expose high 1 cycle, expose_cyc_err one-cycle pulse.
